// File: rtl/pinball_game_ctrl.sv
// Pinball game controller: ball counting, hole scoring with saturation, idle-timeout ball loss.
// Optional combo bonus when built with `define PINBALL_COMBO_BONUS_EN.
module pinball_game_ctrl #(
    parameter int NUM_BALLS   = 8,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int SCORE_MAX   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic [7:0]  getball,
    output logic [2:0]  state,
    output logic [3:0]  ball_num,
    output logic [13:0] score,
    output logic [2:0]  last_hole,
    output logic        hole_valid,
    output logic        game_over
);

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_GET   = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      SAT_VAL   = 16'(SCORE_MAX);

    logic [2:0]       state_q, state_d;
    logic [3:0]       ball_q, ball_d;
    logic [13:0]      score_q, score_d;
    logic [2:0]       last_q, last_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             hit_q, hit_d;
    logic [2:0]       hole_q, hole_d;

    logic        hit_any;
    logic [2:0]  hit_idx;
    logic [4:0]  pts;
    logic [15:0] sum;

    assign hit_any = |getball;

    // Lowest set bit wins when several holes report in the same cycle.
    always_comb begin
        hit_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (getball[i]) hit_idx = 3'(i);
        end
    end

    always_comb begin
        pts = {2'b00, hole_q} + 5'd1;
`ifdef PINBALL_COMBO_BONUS_EN
        if (valid_q && (last_q == hole_q)) pts = {pts[3:0], 1'b0};
`endif
        sum = {2'b00, score_q} + {11'd0, pts};
    end

    always_comb begin
        state_d = state_q;
        ball_d  = ball_q;
        score_d = score_q;
        last_d  = last_q;
        valid_d = valid_q;
        idle_d  = idle_q;
        hit_d   = hit_q;
        hole_d  = hole_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT;
                ball_d  = 4'(NUM_BALLS);
                score_d = 14'd0;
                valid_d = 1'b0;
                idle_d  = '0;
            end
            ST_WAIT: begin
                idle_d = '0;
                if (start_btn) state_d = ST_START;
            end
            ST_START: begin
                idle_d = idle_q + 1'b1;
                if (hit_any) begin
                    state_d = ST_GET;
                    hit_d   = 1'b1;
                    hole_d  = hit_idx;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_GET;
                    hit_d   = 1'b0;
                end
            end
            ST_GET: begin
                ball_d  = (ball_q != 4'd0) ? ball_q - 4'd1 : 4'd0;
                idle_d  = '0;
                state_d = (ball_q <= 4'd1) ? ST_OVER : ST_START;
                if (hit_q) begin
                    score_d = (sum > SAT_VAL) ? SAT_VAL[13:0] : sum[13:0];
                    last_d  = hole_q;
                    valid_d = 1'b1;
                end else begin
`ifdef PINBALL_COMBO_BONUS_EN
                    valid_d = 1'b0;
`endif
                end
            end
            ST_OVER: begin
                if (start_btn) begin
                    state_d = ST_RESET;
                    ball_d  = 4'(NUM_BALLS);
                    score_d = 14'd0;
                    valid_d = 1'b0;
                    idle_d  = '0;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
            ball_q  <= 4'(NUM_BALLS);
            score_q <= 14'd0;
            last_q  <= 3'd0;
            valid_q <= 1'b0;
            idle_q  <= '0;
            hit_q   <= 1'b0;
            hole_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            ball_q  <= ball_d;
            score_q <= score_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            idle_q  <= idle_d;
            hit_q   <= hit_d;
            hole_q  <= hole_d;
        end
    end

    assign state      = state_q;
    assign ball_num   = ball_q;
    assign score      = score_q;
    assign last_hole  = last_q;
    assign hole_valid = valid_q;
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Directed bench for pinball_game_ctrl: vector table plus hand sequences for timeout,
// full game, saturation (second instance, SCORE_MAX=10) and asynchronous reset mid-GET.
module tb_pinball_game_ctrl;

`ifdef PINBALL_COMBO_BONUS_EN
    localparam int COMBO = 1;
`else
    localparam int COMBO = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_btn;
    logic [7:0]  getball;
    logic [2:0]  state, state_s;
    logic [3:0]  ball_num, ball_num_s;
    logic [13:0] score, score_s;
    logic [2:0]  last_hole, last_hole_s;
    logic        hole_valid, hole_valid_s;
    logic        game_over, game_over_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pinball_game_ctrl #(.NUM_BALLS(8), .TIMEOUT_CYC(16), .SCORE_MAX(9999)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .getball(getball),
        .state(state), .ball_num(ball_num), .score(score), .last_hole(last_hole),
        .hole_valid(hole_valid), .game_over(game_over)
    );

    pinball_game_ctrl #(.NUM_BALLS(8), .TIMEOUT_CYC(16), .SCORE_MAX(10)) dut_sat (
        .clk(clk), .rst(rst), .start_btn(start_btn), .getball(getball),
        .state(state_s), .ball_num(ball_num_s), .score(score_s), .last_hole(last_hole_s),
        .hole_valid(hole_valid_s), .game_over(game_over_s)
    );

    typedef struct {
        logic       sb;
        logic [7:0] gb;
        int         st;
        int         bn;
        int         sc;
        int         lh;
        int         hv;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs for one cycle starting at a negedge; return at the next negedge.
    task automatic cycle(input logic sb, input logic [7:0] gb);
        start_btn = sb;
        getball   = gb;
        @(posedge clk);
        @(negedge clk);
        start_btn = 1'b0;
        getball   = 8'd0;
    endtask

    initial begin
        //           sb    gb     st bn  sc            lh hv
        tbl[0]  = '{1'b0, 8'h00, 1, 8,  0,            0, 0};
        tbl[1]  = '{1'b0, 8'h00, 1, 8,  0,            0, 0};
        tbl[2]  = '{1'b0, 8'h01, 1, 8,  0,            0, 0};
        tbl[3]  = '{1'b1, 8'h00, 2, 8,  0,            0, 0};
        tbl[4]  = '{1'b0, 8'h08, 3, 8,  0,            0, 0};
        tbl[5]  = '{1'b0, 8'h00, 2, 7,  4,            3, 1};
        tbl[6]  = '{1'b0, 8'hA0, 3, 7,  4,            3, 1};
        tbl[7]  = '{1'b0, 8'h00, 2, 6,  10,           5, 1};
        tbl[8]  = '{1'b1, 8'h00, 2, 6,  10,           5, 1};
        tbl[9]  = '{1'b0, 8'h20, 3, 6,  10,           5, 1};
        tbl[10] = '{1'b0, 8'h01, 2, 5,  16 + 6*COMBO, 5, 1};

        rst = 1'b1;
        start_btn = 1'b0;
        getball = 8'd0;
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_ball", int'(ball_num), 8);
        chk("reset_score", int'(score), 0);
        chk("reset_game_over", int'(game_over), 0);
        chk("reset_hole_valid", int'(hole_valid), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].sb, tbl[i].gb);
            chk($sformatf("v%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("v%0d_ball", i), int'(ball_num), tbl[i].bn);
            chk($sformatf("v%0d_score", i), int'(score), tbl[i].sc);
            chk($sformatf("v%0d_go", i), int'(game_over), (tbl[i].st == 4) ? 1 : 0);
            if (tbl[i].hv != 0) begin
                chk($sformatf("v%0d_last", i), int'(last_hole), tbl[i].lh);
                chk($sformatf("v%0d_valid", i), int'(hole_valid), 1);
            end
        end

        // Timeout: START just entered with idle=0; GET must appear on the 16th edge.
        for (int k = 1; k <= 15; k++) begin
            cycle(1'b0, 8'h00);
            chk($sformatf("idle%0d_state", k), int'(state), 2);
        end
        cycle(1'b0, 8'h00);
        chk("timeout_get", int'(state), 3);
        cycle(1'b0, 8'h00);
        chk("timeout_back", int'(state), 2);
        chk("timeout_ball", int'(ball_num), 4);
        chk("timeout_score", int'(score), 16 + 6*COMBO);
        chk("timeout_valid", int'(hole_valid), 1 - COMBO);

        // Finish game 1 with four hits on hole 7.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h80);
            chk($sformatf("g1_hit%0d_get", k), int'(state), 3);
            cycle(1'b0, 8'h00);
            chk($sformatf("g1_hit%0d_state", k), int'(state), (k == 3) ? 4 : 2);
            chk($sformatf("g1_hit%0d_ball", k), int'(ball_num), 3 - k);
        end
        chk("g1_score", int'(score), 48 + 30*COMBO);
        chk("g1_game_over", int'(game_over), 1);
        cycle(1'b0, 8'hFF);
        chk("over_hold_state", int'(state), 4);
        chk("over_hold_score", int'(score), 48 + 30*COMBO);
        chk("over_hold_last", int'(last_hole), 7);
        cycle(1'b1, 8'h00);
        chk("over_to_reset", int'(state), 0);
        cycle(1'b0, 8'h00);
        chk("reset_to_wait", int'(state), 1);
        chk("g2_init_score", int'(score), 0);
        chk("g2_init_ball", int'(ball_num), 8);

        // Game 2: eight consecutive hits on hole 7.
        cycle(1'b1, 8'h00);
        chk("g2_start", int'(state), 2);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 8'h80);
            chk($sformatf("g2_hit%0d_get", k), int'(state), 3);
            cycle(1'b0, 8'h00);
            chk($sformatf("g2_hit%0d_state", k), int'(state), (k == 7) ? 4 : 2);
            chk($sformatf("sat_hit%0d_score", k), int'(score_s), (k == 0) ? 8 : 10);
        end
        chk("g2_ball", int'(ball_num), 0);
        chk("g2_score", int'(score), 64 + 56*COMBO);
        chk("g2_game_over", int'(game_over), 1);
        cycle(1'b1, 8'h00);
        chk("g2_reset", int'(state), 0);
        cycle(1'b0, 8'h00);
        chk("g2_wait", int'(state), 1);
        chk("g2_wait_score", int'(score), 0);

        // Asynchronous reset while in GET, no clock edge in between.
        cycle(1'b1, 8'h00);
        cycle(1'b0, 8'h04);
        chk("pre_rst_get", int'(state), 3);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_ball", int'(ball_num), 8);
        chk("arst_score", int'(score), 0);
        chk("arst_last", int'(last_hole), 0);
        chk("arst_valid", int'(hole_valid), 0);
        chk("arst_go", int'(game_over), 0);
        chk("arst_sat_score", int'(score_s), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wait", int'(state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pinball_game_ctrl.md
PINBALL_GAME_CTRL -- requirements
Module: pinball_game_ctrl

Interface
REQ-001 Parameter NUM_BALLS, default 8: balls per game, legal range 1..15.
REQ-002 Parameter TIMEOUT_CYC, default 100_000_000: idle cycles in START before the in-play ball counts as lost.
REQ-003 Parameter SCORE_MAX, default 9999: score saturation ceiling.
REQ-004 clk  input  1  single clock; all registers on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start_btn  input  1  debounced one-pulse start/restart request.
REQ-007 getball  input  8  debounced one-pulse hole hits, bit i = hole i.
REQ-008 state  output  3  game state: RESET=0, WAIT=1, START=2, GET=3, OVER=4.
REQ-009 ball_num  output  4  balls remaining.
REQ-010 score  output  14  accumulated score.
REQ-011 last_hole  output  3  index of most recently scored hole.
REQ-012 hole_valid  output  1  high while last_hole holds a hole scored this game.
REQ-013 game_over  output  1  high exactly when state==OVER.

Function
REQ-014 RESET -> WAIT unconditionally on the next clock edge; ball_num loaded to NUM_BALLS, score to 0, hole_valid to 0.
REQ-015 WAIT -> START on start_btn; otherwise WAIT.
REQ-016 START: idle counter increments every cycle; any getball bit -> GET with captured hole = lowest set bit index.
REQ-017 START: idle counter reaching TIMEOUT_CYC-1 with no getball -> GET flagged as lost ball (no hole captured).
REQ-018 Idle counter cleared on every entry to START.
REQ-019 GET lasts exactly one cycle: ball_num decrements by 1; scored hit adds (hole+1) points, updates last_hole, sets hole_valid; lost ball adds nothing.
REQ-020 Score addition saturates at SCORE_MAX; never wraps.
REQ-021 GET -> OVER when the decremented ball_num is 0; else GET -> START.
REQ-022 OVER -> RESET on start_btn; score and last_hole hold until then.
REQ-023 getball ignored in RESET, WAIT, GET, OVER; start_btn ignored in START and GET.
REQ-024 Multiple getball bits in one cycle: one ball consumed, lowest index scores, others discarded.
REQ-025 getball and timeout in the same cycle: hit wins; treated as scored.
REQ-026 Latency: hit at cycle N in START -> state GET at N+1 -> ball_num/score updated at N+2.
REQ-027 ball_num never decrements below 0.

Reset
REQ-028 rst asserted at any time, including mid-GET: state=RESET, ball_num=NUM_BALLS, score=0, last_hole=0, hole_valid=0, idle counter=0, game_over=0, immediately and asynchronously.
REQ-029 First clock edge after rst deassertion moves RESET -> WAIT.

Configuration
REQ-030 Macro PINBALL_COMBO_BONUS_EN defined: scored hit on the same hole as last_hole while hole_valid=1 adds 2*(hole+1); lost ball clears hole_valid.
REQ-031 Macro undefined: every scored hit adds (hole+1); no combo logic synthesised; hole_valid not cleared by lost balls.

Verification
REQ-032 rst pulse, 2 clocks -> state 0 then 1, ball_num=8, score=0, game_over=0.
REQ-033 WAIT, start_btn, then getball=8'b0000_1000 -> GET one cycle, ball_num=7, score=4, last_hole=3, state back to 2.
REQ-034 getball=8'b1010_0000 single cycle -> ball_num down by 1 only, score +6, last_hole=5.
REQ-035 TIMEOUT_CYC=16, no hits in START -> GET at idle cycle 16, ball_num down by 1, score unchanged; with combo macro hole_valid=0.
REQ-036 8 consecutive hits on hole 7 -> ball_num=0, score=64 (combo off) or 120 (combo on), state=4, game_over=1; start_btn -> RESET then WAIT, score=0.
REQ-037 SCORE_MAX=10, hits on hole 7 twice -> score=10 saturated; rst during GET -> all outputs at reset values same cycle.
